// File: rtl/sm_hex_display.sv
// -----------------------------------------------------------------------------
// sm_hex_display
//
// Purpose:
//   Time-multiplexed driver for a common-anode 7-segment display with up to
//   eight hex digits. A free-running prescaler selects one digit at a time.
//   The displayed value is captured once per frame, so a frame never shows a
//   mix of two different input values.
//
// Parameters:
//   SCAN_SHIFT : prescaler width; the digit advances every 2^SCAN_SHIFT clocks
//   DIGITS     : number of scanned digits, legal range 1..8
//
// Ports:
//   clkIn : clock; all state changes on its rising edge
//   rst   : synchronous, active-high reset
//   data  : value to display; nibble i drives digit i
//   seg   : segments {g,f,e,d,c,b,a}, active-low, registered
//   an    : digit anodes, active-low, one-hot-low, registered
//   dp    : decimal point, active-low, tied off (always 1)
//
// Configuration macro:
//   SM_HEX_LEADING_ZERO_BLANK_EN : when defined, a digit i>0 whose nibble and
//   all higher nibbles of the captured value are zero is blanked (anode and
//   segments off). Digit 0 is never blanked. When undefined, every digit is
//   always lit and no blanking logic exists.
// -----------------------------------------------------------------------------
module sm_hex_display #(
  parameter int SCAN_SHIFT = 16,
  parameter int DIGITS     = 8
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic [31:0] data,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp
);

  // Index of the last scanned digit; the scan wraps to 0 after it.
  localparam logic [2:0] LAST_IDX = 3'(DIGITS - 1);

  // Segment pattern shown for a blanked or reset display (all segments off).
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [7:0] AN_OFF  = 8'hFF;

  // Hex nibble to active-low segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'h40;
      4'h1:    pat = 7'h79;
      4'h2:    pat = 7'h24;
      4'h3:    pat = 7'h30;
      4'h4:    pat = 7'h19;
      4'h5:    pat = 7'h12;
      4'h6:    pat = 7'h02;
      4'h7:    pat = 7'h78;
      4'h8:    pat = 7'h00;
      4'h9:    pat = 7'h10;
      4'hA:    pat = 7'h08;
      4'hB:    pat = 7'h03;
      4'hC:    pat = 7'h46;
      4'hD:    pat = 7'h21;
      4'hE:    pat = 7'h06;
      4'hF:    pat = 7'h0E;
      default: pat = SEG_OFF;
    endcase
    return pat;
  endfunction

  logic [SCAN_SHIFT-1:0] cntr_q, cntr_d;
  logic [2:0]            idx_q,  idx_d;
  logic [31:0]           snap_q, snap_d;
  logic [6:0]            seg_q,  seg_d;
  logic [7:0]            an_q,   an_d;

  logic                  tick_s;
  logic [3:0]            nibble_s;
  logic                  blank_s;

  // Prescaler terminal count: the digit changes on the cycle after this.
  assign tick_s = &cntr_q;

  // Nibble of the captured value belonging to the digit being scanned.
  assign nibble_s = snap_q[{idx_q, 2'b00} +: 4];

`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
  // A leading zero: not digit 0, and this nibble plus everything above it is 0.
  assign blank_s = (idx_q != 3'd0) && ((snap_q >> {idx_q, 2'b00}) == 32'd0);
`else
  assign blank_s = 1'b0;
`endif

  // Next-state logic for prescaler, scan index and frame snapshot.
  always_comb begin
    cntr_d = cntr_q + SCAN_SHIFT'(1);
    idx_d  = idx_q;
    snap_d = snap_q;
    if (tick_s) begin
      if (idx_q == LAST_IDX) begin
        // Frame boundary: restart the scan and capture the new value together
        // so the whole next frame shows one consistent number.
        idx_d  = 3'd0;
        snap_d = data;
      end else begin
        idx_d  = idx_q + 3'd1;
        snap_d = snap_q;
      end
    end else begin
      idx_d  = idx_q;
      snap_d = snap_q;
    end
  end

  // Output decode: anode and segment values for the digit selected this cycle.
  always_comb begin
    an_d         = AN_OFF;
    an_d[idx_q]  = 1'b0;
    seg_d        = hex_decode(nibble_s);
    if (blank_s) begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
    end else begin
      an_d  = an_d;
      seg_d = seg_d;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clkIn) begin
    if (rst) begin
      cntr_q <= '0;
      idx_q  <= 3'd0;
      snap_q <= 32'd0;
      seg_q  <= SEG_OFF;
      an_q   <= AN_OFF;
    end else begin
      cntr_q <= cntr_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      seg_q  <= seg_d;
      an_q   <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = 1'b1;

endmodule

// File: tb/tb_sm_hex_display.sv
module tb_sm_hex_display;

  localparam int SS     = 2;
  localparam int ND     = 8;
  localparam int DWELL  = 1 << SS;      // cycles per digit
  localparam int FRAME  = ND * DWELL;   // cycles per frame

  logic        clkIn = 1'b0;
  logic        rst;
  logic [31:0] data;
  logic [6:0]  seg;
  logic [7:0]  an;
  logic        dp;

  sm_hex_display #(.SCAN_SHIFT(SS), .DIGITS(ND)) dut (
    .clkIn (clkIn),
    .rst   (rst),
    .data  (data),
    .seg   (seg),
    .an    (an),
    .dp    (dp)
  );

  always #5 clkIn = ~clkIn;

  int total = 0;
  int bad   = 0;

  logic [6:0] hex_tab [16];

  // Reference model state: elapsed cycles since reset release and the value
  // that the current frame displays.
  int          n;
  int          md;
  logic [31:0] msnap;
  logic [3:0]  mnib;
  logic [7:0]  exp_an;
  logic [6:0]  exp_seg;
  bit          mvalid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: outputs after each edge follow from the cycle count since release.
  always @(posedge clkIn) begin
    if (rst) begin
      n       = 0;
      msnap   = 32'd0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
    end else begin
      md      = (n / DWELL) % ND;
      mnib    = 4'(msnap >> (4 * md));
      exp_an  = 8'hFF;
      exp_an[md] = 1'b0;
      exp_seg = hex_tab[mnib];
`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
      if (md > 0 && (msnap >> (4 * md)) == 32'd0) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end
`endif
      if (n % FRAME == FRAME - 1) msnap = data;
      n++;
    end
    mvalid = 1'b1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clkIn) begin
    if (mvalid) begin
      chk("model_an", {24'd0, an}, {24'd0, exp_an});
      chk("model_seg", {25'd0, seg}, {25'd0, exp_seg});
      chk("model_dp", {31'd0, dp}, 32'd1);
    end
  end

  task automatic nedge(input int k);
    repeat (k) @(negedge clkIn);
  endtask

  // Wait for the first cycle of a fresh run of an == v (bounded).
  task automatic wait_start(input logic [7:0] v, input string name);
    int  i;
    bit  ok;
    ok = 1'b0;
    for (i = 0; i < 400; i++) begin
      @(negedge clkIn);
      if (an !== v) break;
    end
    for (i = 0; i < 400; i++) begin
      @(negedge clkIn);
      if (an === v) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL %s: timeout waiting for an=%h, last an=%h", name, v, an);
    end
  endtask

  // From the first cycle of a digit, count how many cycles it stays lit.
  task automatic dwell_check(input logic [7:0] v, input string name);
    int cnt;
    cnt = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clkIn);
      if (an === v) cnt++;
      else break;
    end
    chk(name, cnt, 32'(DWELL));
  endtask

  initial begin
    int cnt;
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    rst  = 1'b1;
    data = 32'h89ABCDEF;

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clkIn);
      chk("rst_an", {24'd0, an}, 32'h0000_00FF);
      chk("rst_seg", {25'd0, seg}, 32'h0000_007F);
      chk("rst_dp", {31'd0, dp}, 32'd1);
    end
    rst = 1'b0;
    nedge(1);
    chk("rel_an", {24'd0, an}, 32'h0000_00FE);
    chk("rel_seg", {25'd0, seg}, 32'h0000_0040);
    nedge(3);
    chk("rel_an_hold", {24'd0, an}, 32'h0000_00FE);
    nedge(1);
    chk("rel_an_next", {24'd0, an}, 32'h0000_00FD);

    // Held value 89ABCDEF after the first frame boundary.
    nedge(40);
    wait_start(8'hFE, "d0");
    chk("d0_seg", {25'd0, seg}, 32'h0000_000E);
    dwell_check(8'hFE, "d0_dwell");
    wait_start(8'hEF, "d4");
    chk("d4_seg", {25'd0, seg}, 32'h0000_0003);
    dwell_check(8'hEF, "d4_dwell");
    wait_start(8'h7F, "d7");
    chk("d7_seg", {25'd0, seg}, 32'h0000_0000);
    dwell_check(8'h7F, "d7_dwell");
    // dwell_check stopped on the first cycle after digit 7: the wrap to digit 0.
    chk("wrap_an", {24'd0, an}, 32'h0000_00FE);
    chk("wrap_seg", {25'd0, seg}, 32'h0000_000E);

    // Mid-frame change is ignored until the next boundary.
    data = 32'h12345678;
    wait_start(8'hFE, "f1");
    wait_start(8'hFE, "f2");
    wait_start(8'hF7, "d3");
    data = 32'hFFFFFFFF;
    wait_start(8'hEF, "mid4");
    chk("mid4_seg", {25'd0, seg}, 32'h0000_0019);
    wait_start(8'hDF, "mid5");
    chk("mid5_seg", {25'd0, seg}, 32'h0000_0030);
    wait_start(8'hBF, "mid6");
    chk("mid6_seg", {25'd0, seg}, 32'h0000_0024);
    wait_start(8'h7F, "mid7");
    chk("mid7_seg", {25'd0, seg}, 32'h0000_0079);
    wait_start(8'hFE, "new0");
    chk("new0_seg", {25'd0, seg}, 32'h0000_000E);
    wait_start(8'hF7, "new3");
    chk("new3_seg", {25'd0, seg}, 32'h0000_000E);

    // One-cycle reset pulse mid-frame.
    wait_start(8'hDF, "pre_rst");
    rst = 1'b1;
    nedge(1);
    chk("pulse_an", {24'd0, an}, 32'h0000_00FF);
    chk("pulse_seg", {25'd0, seg}, 32'h0000_007F);
    rst = 1'b0;
    nedge(1);
    chk("after_an", {24'd0, an}, 32'h0000_00FE);
    chk("after_seg", {25'd0, seg}, 32'h0000_0040);
    nedge(3);
    chk("after_hold", {24'd0, an}, 32'h0000_00FE);
    nedge(1);
    chk("after_next", {24'd0, an}, 32'h0000_00FD);

    // Leading-zero behaviour.
    data = 32'h000000A0;
    wait_start(8'hFE, "lz_f1");
    wait_start(8'hFE, "lz_f2");
    chk("lz_d0_seg", {25'd0, seg}, 32'h0000_0040);
    wait_start(8'hFD, "lz_d1");
    chk("lz_d1_seg", {25'd0, seg}, 32'h0000_0008);
    nedge(DWELL);
`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
    chk("lz_d2_an", {24'd0, an}, 32'h0000_00FF);
    chk("lz_d2_seg", {25'd0, seg}, 32'h0000_007F);
`else
    chk("lz_d2_an", {24'd0, an}, 32'h0000_00FB);
    chk("lz_d2_seg", {25'd0, seg}, 32'h0000_0040);
`endif
    data = 32'h0;
    wait_start(8'hFE, "z_f1");
    wait_start(8'hFE, "z_f2");
    cnt = 0;
    for (int i = 0; i < FRAME; i++) begin
      if (an !== 8'hFF && an !== 8'hFE) cnt++;
      nedge(1);
    end
`ifdef SM_HEX_LEADING_ZERO_BLANK_EN
    chk("zero_upper_lit", cnt, 32'd0);
`else
    chk("zero_upper_lit", cnt, 32'(FRAME - DWELL));
`endif

    // Randomized phase checked cycle-by-cycle against the model.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0) data = $urandom >> $urandom_range(0, 31);
      rst = ($urandom_range(0, 299) == 0);
      nedge(1);
    end
    rst = 1'b0;
    nedge(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sm_hex_display.md
SM_HEX_DISPLAY -- requirements
Module: sm_hex_display

Interface
REQ-001 Parameter SCAN_SHIFT, default 16: prescaler width; digit advances every 2^SCAN_SHIFT clocks.
REQ-002 Parameter DIGITS, default 8, legal 1..8: number of scanned hex digits.
REQ-003 Port clkIn  input  1: single clock; all state updates on its rising edge.
REQ-004 Port rst  input  1: reset, synchronous, active-high.
REQ-005 Port data  input  32: value to display, nibble i on digit i; typically the CPU debug register output.
REQ-006 Port seg  output  7: segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 Port an  output  8: digit anodes, active-low, one-hot-low, registered.
REQ-008 Port dp  output  1: decimal point, active-low, constant 1 (off).

Function
REQ-009 The block SHALL hold prescaler cntr (SCAN_SHIFT bits) incrementing every cycle with wrap; tick = (cntr == all ones).
REQ-010 On tick, digit index idx (3 bits) SHALL advance idx+1, wrapping from DIGITS-1 to 0; otherwise it SHALL hold.
REQ-011 On tick with idx == DIGITS-1 (frame boundary), snapshot register snap SHALL load data; otherwise snap SHALL hold, so a frame never mixes two data values.
REQ-012 data changes mid-frame SHALL be ignored until the next frame boundary.
REQ-013 Each cycle an SHALL be registered as all ones except bit idx low; bits >= DIGITS SHALL stay 1.
REQ-014 Each cycle seg SHALL be registered from hex decode of snap[4*idx+3:4*idx]; latency idx/snap -> seg/an is exactly 1 cycle.
REQ-015 Hex decode SHALL be: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E (hex, 7-bit).
REQ-016 Each digit SHALL be lit for exactly 2^SCAN_SHIFT consecutive cycles; frame period = DIGITS*2^SCAN_SHIFT cycles.
REQ-017 DIGITS=1 SHALL keep idx at 0 and reload snap on every tick.

Reset
REQ-018 While rst is high at a clock edge: cntr=0, idx=0, snap=0, an=8'hFF, seg=7'h7F, dp=1.
REQ-019 Reset asserted mid-frame SHALL abort the frame; first cycle after release SHALL show an=8'hFE, seg=7'h40 (snap=0, digit 0).
REQ-020 snap SHALL first load data at the first frame boundary after reset release.

Configuration
REQ-021 Macro SM_HEX_LEADING_ZERO_BLANK_EN defined: a digit i>0 with snap[31:4*i] == 0 SHALL be blanked (an bit held 1, seg=7'h7F); digit 0 SHALL never blank.
REQ-022 Macro undefined: all DIGITS digits SHALL always be lit, leading zeros shown as 7'h40; no blanking logic synthesized.

Verification (SCAN_SHIFT=2, DIGITS=8, tick every 4 cycles, frame 32 cycles)
REQ-023 rst high 3 cycles -> an=FF, seg=7F, dp=1 throughout; first cycle after release an=FE, seg=40; an=FD appears 4 cycles later.
REQ-024 data=32'h89ABCDEF held, after first frame boundary -> digit0 an=FE seg=0E, digit4 an=EF seg=03, digit7 an=7F seg=00, each lasting exactly 4 cycles.
REQ-025 data=32'h12345678, switched to 32'hFFFFFFFF while an=F7 -> digits 4..7 still show 4,3,2,1 (19,30,24,79); next frame all digits seg=0E.
REQ-026 Wrap: an=7F for 4 cycles then an=FE; snap reload coincides with idx 7->0.
REQ-027 rst pulsed 1 cycle while an=DF -> next cycle an=FF seg=7F; following cycle an=FE seg=40; realignment from cntr=0.
REQ-028 data=32'h000000A0 with macro -> an toggles only FE/FD, digit1 seg=08, digit0 seg=40, an=FF for idx 2..7; without macro digits 2..7 show seg=40; data=0 with macro -> only digit 0 lit.
